// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch/decode sequencer that owns the PC and hands each instruction
// word to the execution FSMs. Optional build macro: SINGLE_STEP_EN (adds the step input).
module instr_fetch_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
`ifdef SINGLE_STEP_EN
   input  logic              step,
`endif
   input  logic [15:0]       mem_data,
   input  logic              mem_ack,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              PC_inc,
   input  logic              exec_done,
   output logic [15:0]       fullBitNum,
   output logic [1:0]        op_class,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              fault
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_class_q, op_class_d;
   logic              mem_rd_q, mem_rd_d;
   logic [15:0]       full_q, full_d;
   logic              halted_q, halted_d;
   logic              fault_q, fault_d;
   logic              start_ok;
   logic              cont_ok;

`ifdef SINGLE_STEP_EN
   logic              step_q, step_d;

   // Single-step: start only on a step rising edge, always park in IDLE after completion.
   assign step_d   = step;
   assign start_ok = step & ~step_q;
   assign cont_ok  = 1'b0;
`else
   assign start_ok = run;
   assign cont_ok  = run;
`endif

   // Next-state, PC, instruction register and timeout counter; outputs follow the next state.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      cnt_d      = cnt_q;
      op_class_d = op_class_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (mem_ack) begin
               ir_d    = mem_data;
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            cnt_d = '0;
            case (ir_q[15:12])
               4'b0000: begin
                  op_class_d = 2'b00;
                  pc_d       = pc_q + PC_ONE;
                  state_d    = cont_ok ? S_FETCH : S_IDLE;
               end
               4'b0001, 4'b0010: begin
                  op_class_d = 2'b01;
                  state_d    = S_EXEC;
               end
               4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                  op_class_d = 2'b10;
                  state_d    = S_EXEC;
               end
               4'b1111: begin
                  op_class_d = 2'b11;
                  state_d    = S_HALT;
               end
               default: begin
                  op_class_d = 2'b11;
                  state_d    = S_ERR;
               end
            endcase
         end
         S_EXEC: begin
            if (PC_inc) begin
               pc_d = pc_q + PC_ONE;
            end else begin
               pc_d = pc_q;
            end
            // exec_done takes priority over the timeout on the final allowed cycle
            if (exec_done) begin
               cnt_d   = '0;
               state_d = cont_ok ? S_FETCH : S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
      mem_rd_d = (state_d == S_FETCH);
      full_d   = (state_d == S_EXEC) ? ir_d : 16'h0000;
      halted_d = (state_d == S_HALT);
      fault_d  = (state_d == S_ERR);
   end

   // State and registered outputs; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         ir_q       <= 16'h0000;
         cnt_q      <= '0;
         op_class_q <= 2'b00;
         mem_rd_q   <= 1'b0;
         full_q     <= 16'h0000;
         halted_q   <= 1'b0;
         fault_q    <= 1'b0;
`ifdef SINGLE_STEP_EN
         step_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         cnt_q      <= cnt_d;
         op_class_q <= op_class_d;
         mem_rd_q   <= mem_rd_d;
         full_q     <= full_d;
         halted_q   <= halted_d;
         fault_q    <= fault_d;
`ifdef SINGLE_STEP_EN
         step_q     <= step_d;
`endif
      end
   end

   assign mem_rd     = mem_rd_q;
   assign mem_addr   = pc_q;
   assign fullBitNum = full_q;
   assign op_class   = op_class_q;
   assign pc         = pc_q;
   assign halted     = halted_q;
   assign fault      = fault_q;

endmodule
